// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered value, blanking gap between digits.
// Optional leading-zero blanking when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic                  load,
  output logic [3:0]            symbol,
  output logic                  dp,
  output logic [DIGITS-1:0]     COM
);

  localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(DIGITS);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx, w_idx_nxt;
  logic [4*DIGITS-1:0]   r_pend_val, r_act_val, w_act_val_nxt;
  logic [DIGITS-1:0]     r_pend_dp, r_act_dp, w_act_dp_nxt;
  logic [3:0]            w_sym_nxt;
  logic                  w_dp_nxt;
  logic [DIGITS-1:0]     w_com_nxt;
  logic [DIGITS-1:0]     w_onehot;
  logic [DIGITS-1:0]     w_supp;
  logic                  w_blank_done, w_show_done, w_frame_end;

  assign w_blank_done = (r_cnt == CNT_W'(BLANK_CYC - 1));
  assign w_show_done  = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_frame_end  = (r_state == ST_SHOW) && w_show_done && (r_idx == IDX_W'(DIGITS - 1));
  assign w_onehot     = {{(DIGITS-1){1'b0}}, 1'b1} << r_idx;

`ifdef SEG_SCAN_LZB_EN
  // A digit is suppressed when it and every more-significant digit carry neither value nor dp.
  always_comb begin
    logic v_zero;
    v_zero = 1'b1;
    w_supp = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      v_zero    = v_zero && (r_act_val[4*i +: 4] == 4'h0) && !r_act_dp[i];
      w_supp[i] = v_zero;
    end
  end
`else
  assign w_supp = '0;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt + 1'b1;
    w_idx_nxt     = r_idx;
    w_com_nxt     = '0;
    w_sym_nxt     = symbol;
    w_dp_nxt      = dp;
    w_act_val_nxt = r_act_val;
    w_act_dp_nxt  = r_act_dp;

    // A load landing on the boundary bypasses the pending buffer so it is not a frame late.
    if (w_frame_end) begin
      w_act_val_nxt = load ? value   : r_pend_val;
      w_act_dp_nxt  = load ? dp_mask : r_pend_dp;
    end

    case (r_state)
      ST_BLANK: begin
        if (w_blank_done) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = '0;
          w_com_nxt   = w_onehot & ~w_supp;
        end
      end
      ST_SHOW: begin
        if (w_show_done) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = (r_idx == IDX_W'(DIGITS - 1)) ? '0 : r_idx + 1'b1;
          w_sym_nxt   = w_act_val_nxt[{w_idx_nxt, 2'b00} +: 4];
          w_dp_nxt    = w_act_dp_nxt[w_idx_nxt];
        end else begin
          w_com_nxt   = w_onehot & ~w_supp;
        end
      end
      default: begin
        w_state_nxt = ST_BLANK;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_BLANK;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_act_val  <= '0;
      r_act_dp   <= '0;
      symbol     <= 4'h0;
      dp         <= 1'b0;
      COM        <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      if (load) begin
        r_pend_val <= value;
        r_pend_dp  <= dp_mask;
      end
      r_act_val <= w_act_val_nxt;
      r_act_dp  <= w_act_dp_nxt;
      symbol    <= w_sym_nxt;
      dp        <= w_dp_nxt;
      COM       <= w_com_nxt;
    end
  end

endmodule
